// File: rtl/team_02_wbm_pkg.sv
// Shared types and default sizing for the team_02 Wishbone classic master engine.
package team_02_wbm_pkg;

    // Engine states: waiting for a request, running a bus cycle, presenting a response
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wbm_state_t;

    localparam int WBM_ADDR_W      = 32;
    localparam int WBM_DATA_W      = 32;
    localparam int WBM_TIMEOUT_CYC = 255;

endpackage

// File: rtl/team_02_wbm_engine_if.sv
// Core request/response channel plus Wishbone classic master signals of the engine.
interface team_02_wbm_engine_if
    import team_02_wbm_pkg::*;
#(
    parameter int ADDR_W = WBM_ADDR_W,
    parameter int DATA_W = WBM_DATA_W
);
    // Core-side request channel
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_sel;

    // Core-side response channel
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;
    logic                  busy;

    // Wishbone classic master side
    logic [ADDR_W-1:0]     ADR_O;
    logic [DATA_W-1:0]     DAT_O;
    logic [DATA_W/8-1:0]   SEL_O;
    logic                  WE_O;
    logic                  STB_O;
    logic                  CYC_O;
    logic [DATA_W-1:0]     DAT_I;
    logic                  ACK_I;

    // The engine itself
    modport master (
        input  req_valid, req_we, req_addr, req_wdata, req_sel,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err, busy,
        input  rsp_ready,
        output ADR_O, DAT_O, SEL_O, WE_O, STB_O, CYC_O,
        input  DAT_I, ACK_I
    );

    // The surroundings: requesting core and Wishbone slave
    modport slave (
        output req_valid, req_we, req_addr, req_wdata, req_sel,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err, busy,
        output rsp_ready,
        input  ADR_O, DAT_O, SEL_O, WE_O, STB_O, CYC_O,
        output DAT_I, ACK_I
    );

endinterface

// File: rtl/team_02_wbm_timeout.sv
// Loadable up-counter measuring how long STB_O has waited for ACK_I.
// tc flags the last permitted wait cycle; the count saturates instead of wrapping.
module team_02_wbm_timeout
    import team_02_wbm_pkg::*;
#(
    parameter int TIMEOUT_CYC = WBM_TIMEOUT_CYC,
    parameter int CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             en,
    output logic             tc
);

    localparam logic [CNT_W-1:0] TC_VAL  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] count;

    // Clear has priority over load, load over counting; hold at all-ones so it never wraps
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == TC_VAL);

endmodule

// File: rtl/team_02_wbm_engine.sv
// Wishbone classic single-transfer master: one request in, one bus cycle out,
// one response back, with an ACK timeout that aborts a stuck cycle.
module team_02_wbm_engine
    import team_02_wbm_pkg::*;
#(
    parameter int ADDR_W      = WBM_ADDR_W,
    parameter int DATA_W      = WBM_DATA_W,
    parameter int TIMEOUT_CYC = WBM_TIMEOUT_CYC
) (
    input logic                  clk,
    input logic                  nrst,
    team_02_wbm_engine_if.master bus
);

    localparam int SEL_W = DATA_W / 8;
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    wbm_state_t state;
    logic       accept;
    logic       start_bus;
    logic       tmo_tc;

    assign accept    = (state == IDLE) && bus.req_valid && bus.req_ready;
    assign start_bus = accept && (bus.req_sel != {SEL_W{1'b0}});

    team_02_wbm_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W)
    ) u_timeout (
        .clk        (clk),
        .nrst       (nrst),
        .clr        (start_bus),
        .load       (1'b0),
        .load_value ({CNT_W{1'b0}}),
        .en         (bus.STB_O),
        .tc         (tmo_tc)
    );

    // Transfer FSM; every output is a register updated alongside the state
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state         <= IDLE;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
            bus.busy      <= 1'b0;
            bus.ADR_O     <= '0;
            bus.DAT_O     <= '0;
            bus.SEL_O     <= '0;
            bus.WE_O      <= 1'b0;
            bus.STB_O     <= 1'b0;
            bus.CYC_O     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_bus) begin
                        bus.ADR_O     <= bus.req_addr[ADDR_W-1:0];
                        bus.DAT_O     <= bus.req_wdata;
                        bus.SEL_O     <= bus.req_sel;
                        bus.WE_O      <= bus.req_we;
                        bus.STB_O     <= 1'b1;
                        bus.CYC_O     <= 1'b1;
                        bus.req_ready <= 1'b0;
                        bus.busy      <= 1'b1;
                        state         <= BUS;
                    end else if (accept) begin
                        // No byte lanes enabled: refuse without touching the bus
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_rdata <= '0;
                        bus.req_ready <= 1'b0;
                        bus.busy      <= 1'b1;
                        state         <= RESP;
                    end
                end
                BUS: begin
                    if (bus.ACK_I) begin
                        // ACK beats a simultaneous terminal count
                        bus.STB_O     <= 1'b0;
                        bus.CYC_O     <= 1'b0;
                        bus.rsp_rdata <= bus.WE_O ? '0 : bus.DAT_I;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end else if (tmo_tc) begin
                        bus.STB_O     <= 1'b0;
                        bus.CYC_O     <= 1'b0;
                        bus.rsp_rdata <= '0;
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.req_ready <= 1'b1;
                        bus.busy      <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_team_02_wbm_engine.sv
// Randomized and directed bench for team_02_wbm_engine against a transaction-level model.
module tb_team_02_wbm_engine;
    import team_02_wbm_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int TMO    = 8;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [15:0] stb_cycles;
        logic [15:0] latency;
    } resp_t;

    logic clk  = 1'b0;
    logic nrst = 1'b0;

    int check_count = 0;
    int pass_count  = 0;

    always #5 clk = ~clk;

    team_02_wbm_engine_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    team_02_wbm_engine #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_count++;
        if (observed === expected) pass_count++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    // Expected outcome of one transfer: ack_delay is the number of STB cycles
    // without ACK before the slave acknowledges.
    function automatic resp_t model_response(input bit we, input logic [3:0] sel,
                                             input int ack_delay, input logic [31:0] rdata_val);
        resp_t r;
        if (sel == 4'h0) begin
            r.rdata = 32'h0; r.err = 1'b1; r.stb_cycles = 16'd0; r.latency = 16'd1;
        end else if (ack_delay + 1 <= TMO) begin
            r.rdata      = we ? 32'h0 : rdata_val;
            r.err        = 1'b0;
            r.stb_cycles = 16'(ack_delay + 1);
            r.latency    = 16'(ack_delay + 2);
        end else begin
            r.rdata = 32'h0; r.err = 1'b1; r.stb_cycles = 16'(TMO); r.latency = 16'(TMO + 1);
        end
        return r;
    endfunction

    task automatic apply_stimulus(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [3:0] sel, input int ack_delay,
                                  input logic [31:0] rdata_val, input int stall);
        resp_t exp;
        int    stb_seen;
        int    lat;
        bit    got;
        exp      = model_response(we, sel, ack_delay, rdata_val);
        stb_seen = 0;
        lat      = 0;
        got      = 1'b0;
        bus.ACK_I     = 1'b0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 20 && !bus.req_ready; i++) @(negedge clk);
        check_output("req_ready_idle", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_sel   = sel;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_we    = 1'($urandom_range(0, 1));
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        bus.req_sel   = 4'($urandom_range(0, 15));
        for (int c = 1; c <= 40; c++) begin
            if (bus.rsp_valid) begin
                got = 1'b1;
                lat = c;
                break;
            end
            check_output("busy_in_bus", bus.busy, 1);
            check_output("req_ready_in_bus", bus.req_ready, 0);
            if (bus.STB_O) begin
                stb_seen++;
                check_output("adr_stable", bus.ADR_O, addr);
                check_output("dat_stable", bus.DAT_O, wdata);
                check_output("sel_stable", bus.SEL_O, sel);
                check_output("we_stable", bus.WE_O, we);
                check_output("cyc_with_stb", bus.CYC_O, 1);
                bus.ACK_I = (stb_seen == ack_delay + 1);
                bus.DAT_I = bus.ACK_I ? rdata_val : $urandom;
            end else begin
                bus.ACK_I = 1'b0;
            end
            @(negedge clk);
        end
        bus.ACK_I = 1'b0;
        check_output("rsp_wait", got, 1);
        check_output("rsp_rdata", bus.rsp_rdata, exp.rdata);
        check_output("rsp_err", bus.rsp_err, exp.err);
        check_output("stb_cycles", stb_seen, exp.stb_cycles);
        check_output("latency", lat, exp.latency);
        check_output("cyc_after", bus.CYC_O, 0);
        check_output("stb_after", bus.STB_O, 0);
        // Hold the response back while poking stray ACKs and a would-be new request
        for (int s = 0; s < stall; s++) begin
            bus.ACK_I     = 1'($urandom_range(0, 1));
            bus.DAT_I     = $urandom;
            bus.req_valid = 1'b1;
            bus.req_sel   = 4'hF;
            @(negedge clk);
            check_output("stall_rsp_valid", bus.rsp_valid, 1);
            check_output("stall_rdata", bus.rsp_rdata, exp.rdata);
            check_output("stall_err", bus.rsp_err, exp.err);
            check_output("stall_req_ready", bus.req_ready, 0);
            check_output("stall_no_cyc", bus.CYC_O, 0);
        end
        bus.ACK_I     = 1'b0;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check_output("done_rsp_valid", bus.rsp_valid, 0);
        check_output("done_req_ready", bus.req_ready, 1);
        check_output("done_busy", bus.busy, 0);
    endtask

    task automatic stray_ack_idle();
        bus.ACK_I = 1'b1;
        bus.DAT_I = $urandom;
        @(negedge clk);
        bus.ACK_I = 1'b0;
        check_output("idle_ack_busy", bus.busy, 0);
        check_output("idle_ack_ready", bus.req_ready, 1);
        check_output("idle_ack_cyc", bus.CYC_O, 0);
        check_output("idle_ack_rsp", bus.rsp_valid, 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit          we;
        logic [3:0]  sel;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_sel   = '0;
        bus.rsp_ready = 1'b0;
        bus.DAT_I     = '0;
        bus.ACK_I     = 1'b0;
        nrst          = 1'b0;
        repeat (2) @(negedge clk);
        check_output("rst_req_ready", bus.req_ready, 1);
        check_output("rst_rsp_valid", bus.rsp_valid, 0);
        check_output("rst_busy", bus.busy, 0);
        check_output("rst_cyc", bus.CYC_O, 0);
        check_output("rst_stb", bus.STB_O, 0);
        check_output("rst_err", bus.rsp_err, 0);
        check_output("rst_rdata", bus.rsp_rdata, 0);
        check_output("rst_adr", bus.ADR_O, 0);
        nrst = 1'b1;
        @(negedge clk);

        $display("[TB] directed transfers");
        apply_stimulus(1'b0, 32'h3000_0010, 32'h0, 4'hF, 1, 32'hDEAD_BEEF, 0);
        apply_stimulus(1'b1, 32'h3000_0004, 32'h1234_5678, 4'h3, 2, 32'hCAFE_F00D, 0);
        apply_stimulus(1'b0, 32'h3000_0020, 32'h0, 4'hF, 100, 32'h5555_AAAA, 1);
        apply_stimulus(1'b0, 32'h3000_0024, 32'h0, 4'hF, TMO - 1, 32'hA5A5_0F0F, 0);
        stray_ack_idle();
        apply_stimulus(1'b0, 32'h3000_0028, 32'h0, 4'hF, 0, 32'h0BAD_CAFE, 5);
        apply_stimulus(1'b1, 32'h3000_002C, 32'h7777_8888, 4'h0, 0, 32'h0, 2);

        $display("[TB] reset during bus cycle");
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h3000_0030;
        bus.req_sel   = 4'hF;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_output("pre_rst_stb", bus.STB_O, 1);
        #2 nrst = 1'b0;
        #1;
        check_output("async_rst_cyc", bus.CYC_O, 0);
        check_output("async_rst_stb", bus.STB_O, 0);
        check_output("async_rst_ready", bus.req_ready, 1);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        check_output("post_rst_ready", bus.req_ready, 1);
        check_output("post_rst_busy", bus.busy, 0);
        apply_stimulus(1'b0, 32'h3000_0034, 32'h0, 4'hF, 1, 32'h1357_9BDF, 0);

        $display("[TB] randomized transfers");
        for (int t = 0; t < 40; t++) begin
            we  = 1'($urandom_range(0, 1));
            sel = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            apply_stimulus(we, $urandom, $urandom, sel, $urandom_range(0, 10), $urandom,
                           $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) stray_ack_idle();
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
